// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Instruction-fetch queue between the PC register and decode.
//                Issues in-order requests to instruction memory, buffers the
//                returned words with their PC in a DEPTH-entry ring, and
//                offers the head entry to IF/ID with a valid/ready handshake.
//                A flush discards queued entries and counts in-flight
//                responses so that each one is dropped exactly once.
//  Options     : `define FETCH_MISALIGN_CHK_EN to word-align imem_addr and
//                flag misaligned PCs on id_misalign.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_valid,
    input  logic [31:0] pc_addr,
    output logic        pc_ready,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        id_ready
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic        id_misalign
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    // Pointers and counters carry one extra bit so full and empty differ.
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_FULL_OCC = CNT_W'(DEPTH);

    logic [CNT_W-1:0] r_alloc;
    logic [CNT_W-1:0] r_fill;
    logic [CNT_W-1:0] r_read;
    logic [CNT_W-1:0] r_drop;

    logic [31:0] r_pc_mem    [DEPTH];
    logic [31:0] r_instr_mem [DEPTH];
`ifdef FETCH_MISALIGN_CHK_EN
    logic        r_mis_mem   [DEPTH];
`endif

    logic [CNT_W-1:0] w_occ;
    logic [CNT_W-1:0] w_inflight;
    logic             w_drop_idle;
    logic             w_fill_en;
    logic             w_drop_en;
    logic             w_pop;
    logic [PTR_W-1:0] w_alloc_idx;
    logic [PTR_W-1:0] w_fill_idx;
    logic [PTR_W-1:0] w_read_idx;

    // Occupancy counts allocated-but-not-popped entries, so it bounds
    // queued plus in-flight fetches together.
    assign w_occ       = r_alloc - r_read;
    assign w_inflight  = r_alloc - r_fill;
    assign w_drop_idle = (r_drop == '0);
    assign w_fill_en   = imem_rvalid &  w_drop_idle;
    assign w_drop_en   = imem_rvalid & ~w_drop_idle;
    assign w_alloc_idx = r_alloc[PTR_W-1:0];
    assign w_fill_idx  = r_fill[PTR_W-1:0];
    assign w_read_idx  = r_read[PTR_W-1:0];

    // New requests wait until every response from before a flush is gone.
    assign imem_req = pc_valid & ~flush & w_drop_idle & (w_occ < c_FULL_OCC);
    assign pc_ready = imem_req & imem_gnt;

`ifdef FETCH_MISALIGN_CHK_EN
    assign imem_addr = {pc_addr[31:2], 2'b00};
`else
    assign imem_addr = pc_addr;
`endif

    // Head is offered only once its response has landed; no fill bypass.
    assign id_valid = (r_read != r_fill) & ~flush;
    assign id_pc    = r_pc_mem[w_read_idx];
    assign id_instr = r_instr_mem[w_read_idx];
    assign w_pop    = id_valid & id_ready;

`ifdef FETCH_MISALIGN_CHK_EN
    assign id_misalign = id_valid & r_mis_mem[w_read_idx];
`endif

    // Pointer and drop-counter update; flush overrides grant, fill and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alloc <= '0;
            r_fill  <= '0;
            r_read  <= '0;
            r_drop  <= '0;
        end else if (flush) begin
            r_alloc <= '0;
            r_fill  <= '0;
            r_read  <= '0;
            // Every outstanding response, including one arriving now, is
            // retired exactly once: either consumed this cycle or counted.
            r_drop  <= w_inflight - CNT_W'(w_fill_en) + r_drop - CNT_W'(w_drop_en);
        end else begin
            if (pc_ready) begin
                r_alloc <= r_alloc + 1'b1;
            end
            if (w_fill_en) begin
                r_fill <= r_fill + 1'b1;
            end
            if (w_drop_en) begin
                r_drop <= r_drop - 1'b1;
            end
            if (w_pop) begin
                r_read <= r_read + 1'b1;
            end
        end
    end

    // Entry payload storage; contents are only observed through valid pointers.
    always_ff @(posedge clk) begin
        if (pc_ready) begin
            r_pc_mem[w_alloc_idx] <= pc_addr;
        end
        if (w_fill_en) begin
            r_instr_mem[w_fill_idx] <= imem_rdata;
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    // Misalignment flag captured alongside the PC at allocation.
    always_ff @(posedge clk) begin
        if (pc_ready) begin
            r_mis_mem[w_alloc_idx] <= |pc_addr[1:0];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Self-checking bench for fetch_queue with an in-order memory
//                model and a scoreboard of expected {pc, instr} deliveries.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_valid;
    logic [31:0] pc_addr;
    logic        pc_ready;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        id_misalign;
`endif

    fetch_queue #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_valid    (pc_valid),
        .pc_addr     (pc_addr),
        .pc_ready    (pc_ready),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_ready    (id_ready)
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        .id_misalign (id_misalign)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          rdy;
    } mreq_t;

    exp_t  exp_q[$];
    mreq_t mem_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_grants = 0;
    int n_pops   = 0;
    int resp_extra = 0;
    bit gnt_en  = 1'b0;
    bit auto_pc = 1'b1;

    logic        s_pc_ready;
    logic        s_imem_req;
    logic        s_id_valid;
    logic [31:0] s_imem_addr;
    logic [31:0] s_id_pc;
    logic        s_id_mis;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] exp_addr(input logic [31:0] a);
`ifdef FETCH_MISALIGN_CHK_EN
        return {a[31:2], 2'b00};
`else
        return a;
`endif
    endfunction

    function automatic logic mis_of(input logic [31:0] a);
`ifdef FETCH_MISALIGN_CHK_EN
        return |a[1:0];
`else
        return 1'b0;
`endif
    endfunction

    // One clock cycle: memory response, settle, scoreboard, advance.
    task automatic tick();
        exp_t e;
        logic mis_now;
        if (mem_q.size() > 0 && cyc >= mem_q[0].rdy) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        // Memory only grants an actual request.
        imem_gnt = gnt_en && imem_req;
        #1;
        s_pc_ready  = pc_ready;
        s_imem_req  = imem_req;
        s_id_valid  = id_valid;
        s_imem_addr = imem_addr;
        s_id_pc     = id_pc;
`ifdef FETCH_MISALIGN_CHK_EN
        mis_now = id_misalign;
`else
        mis_now = 1'b0;
`endif
        s_id_mis = mis_now;
        if (flush) begin
            total++;
            if ({pc_ready, id_valid} !== 2'b00) begin
                bad++;
                $display("FAIL flush_quiet: pc_ready,id_valid=%b required 00", {pc_ready, id_valid});
            end
        end
        if (pc_ready) begin
            total++;
            if (imem_addr !== exp_addr(pc_addr)) begin
                bad++;
                $display("FAIL imem_addr: got %h required %h", imem_addr, exp_addr(pc_addr));
            end
            mem_q.push_back('{imem_addr, cyc + 1 + resp_extra});
            exp_q.push_back('{pc_addr, word_of(exp_addr(pc_addr)), mis_of(pc_addr)});
            n_grants++;
        end
        if (id_valid && id_ready) begin
            n_pops++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pop: id_pc=%h id_instr=%h required no delivery", id_pc, id_instr);
            end else begin
                e = exp_q.pop_front();
                if (id_pc !== e.pc || id_instr !== e.instr || mis_now !== e.mis) begin
                    bad++;
                    $display("FAIL deliver: pc=%h instr=%h mis=%b required pc=%h instr=%h mis=%b",
                             id_pc, id_instr, mis_now, e.pc, e.instr, e.mis);
                end
            end
        end
        if (flush) exp_q.delete();
        @(posedge clk);
        #1;
        cyc++;
        if (auto_pc && s_pc_ready) pc_addr = pc_addr + 32'd4;
    endtask

    task automatic drain();
        int n;
        pc_valid = 1'b0;
        flush    = 1'b0;
        id_ready = 1'b1;
        gnt_en   = 1'b1;
        n = 0;
        while ((exp_q.size() > 0 || mem_q.size() > 0) && n < 40) begin
            tick();
            n++;
        end
        tick();
        total++;
        if (exp_q.size() != 0 || mem_q.size() != 0 || s_id_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain: exp_left=%0d mem_left=%0d id_valid=%b required 0 0 0",
                     exp_q.size(), mem_q.size(), s_id_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pc_valid = 1'b0; pc_addr = '0; flush = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({imem_req, pc_ready, id_valid} !== 3'b000) begin
            bad++;
            $display("FAIL reset_outputs: req,ready,valid=%b required 000", {imem_req, pc_ready, id_valid});
        end
`ifdef FETCH_MISALIGN_CHK_EN
        total++;
        if (id_misalign !== 1'b0) begin
            bad++;
            $display("FAIL reset_misalign: got %b required 0", id_misalign);
        end
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (id_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_valid: got %b required 0", id_valid);
        end
    endtask

    task automatic test_stream();
        id_ready = 1'b1; gnt_en = 1'b1; pc_addr = 32'h0; resp_extra = 0;
        for (int i = 0; i < 5; i++) begin
            pc_valid = (i < 3);
            tick();
            total++;
            if (s_pc_ready !== (i < 3)) begin
                bad++;
                $display("FAIL stream_pc_ready[%0d]: got %b required %b", i, s_pc_ready, (i < 3));
            end
            total++;
            if (s_id_valid !== (i >= 2)) begin
                bad++;
                $display("FAIL stream_id_valid[%0d]: got %b required %b", i, s_id_valid, (i >= 2));
            end
        end
        drain();
    endtask

    task automatic test_full();
        int g0;
        id_ready = 1'b0; gnt_en = 1'b1; pc_valid = 1'b1; pc_addr = 32'h1000;
        g0 = n_grants;
        repeat (8) tick();
        total++;
        if (n_grants - g0 != 4 || s_imem_req !== 1'b0) begin
            bad++;
            $display("FAIL full_grants: grants=%0d req=%b required 4 0", n_grants - g0, s_imem_req);
        end
        id_ready = 1'b1;
        tick();
        total++;
        if (s_pc_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_pop_cycle: pc_ready=%b required 0", s_pc_ready);
        end
        id_ready = 1'b0;
        tick();
        total++;
        if (s_pc_ready !== 1'b1) begin
            bad++;
            $display("FAIL full_reissue: pc_ready=%b required 1", s_pc_ready);
        end
        tick();
        total++;
        if (s_imem_req !== 1'b0) begin
            bad++;
            $display("FAIL full_again: imem_req=%b required 0", s_imem_req);
        end
        drain();
    endtask

    task automatic test_stall();
        int g0;
        id_ready = 1'b1; gnt_en = 1'b0; pc_valid = 1'b1; pc_addr = 32'h10;
        g0 = n_grants;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (s_pc_ready !== 1'b0 || s_imem_req !== 1'b1 || s_imem_addr !== 32'h10) begin
                bad++;
                $display("FAIL stall[%0d]: ready=%b req=%b addr=%h required 0 1 00000010",
                         i, s_pc_ready, s_imem_req, s_imem_addr);
            end
        end
        total++;
        if (n_grants != g0) begin
            bad++;
            $display("FAIL stall_alloc: grants=%0d required 0", n_grants - g0);
        end
        gnt_en = 1'b1;
        tick();
        pc_valid = 1'b0;
        total++;
        if (s_pc_ready !== 1'b1) begin
            bad++;
            $display("FAIL stall_release: pc_ready=%b required 1", s_pc_ready);
        end
        drain();
    endtask

    task automatic test_flush_inflight();
        int k;
        int p0;
        resp_extra = 3; gnt_en = 1'b1; id_ready = 1'b1; pc_valid = 1'b1; pc_addr = 32'h40;
        tick();
        tick();
        pc_addr = 32'h200; flush = 1'b1;
        tick();
        flush = 1'b0; resp_extra = 0;
        p0 = n_pops;
        k = 0;
        while (k < 12) begin
            tick();
            if (s_pc_ready) break;
            k++;
        end
        pc_valid = 1'b0;
        total++;
        if (k != 3) begin
            bad++;
            $display("FAIL flush_resume: idle cycles=%0d required 3", k);
        end
        drain();
        total++;
        if (n_pops - p0 != 1) begin
            bad++;
            $display("FAIL flush_deliveries: got %0d required 1", n_pops - p0);
        end
    endtask

    task automatic test_flush_collide();
        int p0;
        resp_extra = 1; gnt_en = 1'b1; id_ready = 1'b0; pc_valid = 1'b1; pc_addr = 32'h80;
        tick();
        tick();
        tick();
        resp_extra = 0;
        pc_addr = 32'h300; flush = 1'b1;
        tick();
        flush = 1'b0; id_ready = 1'b1;
        p0 = n_pops;
        tick();
        total++;
        if (s_imem_req !== 1'b0) begin
            bad++;
            $display("FAIL collide_drop: imem_req=%b required 0", s_imem_req);
        end
        tick();
        total++;
        if (s_pc_ready !== 1'b1) begin
            bad++;
            $display("FAIL collide_resume: pc_ready=%b required 1", s_pc_ready);
        end
        tick();
        pc_valid = 1'b0;
        drain();
        total++;
        if (n_pops - p0 != 2) begin
            bad++;
            $display("FAIL collide_deliveries: got %0d required 2", n_pops - p0);
        end
    endtask

`ifdef FETCH_MISALIGN_CHK_EN
    task automatic test_misalign();
        int n;
        resp_extra = 0; gnt_en = 1'b1; id_ready = 1'b1; pc_valid = 1'b1; pc_addr = 32'h102;
        tick();
        pc_valid = 1'b0;
        total++;
        if (s_imem_addr !== 32'h100) begin
            bad++;
            $display("FAIL mis_addr: got %h required 00000100", s_imem_addr);
        end
        n = 0;
        do begin
            tick();
            n++;
        end while (!s_id_valid && n < 6);
        total++;
        if (s_id_valid !== 1'b1 || s_id_mis !== 1'b1 || s_id_pc !== 32'h102) begin
            bad++;
            $display("FAIL mis_head: valid=%b mis=%b pc=%h required 1 1 00000102",
                     s_id_valid, s_id_mis, s_id_pc);
        end
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_stall();
        test_flush_inflight();
        test_flush_collide();
`ifdef FETCH_MISALIGN_CHK_EN
        test_misalign();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
